// File: rtl/axil_ram_ctrl.sv
// axil_ram_ctrl
// AXI4-Lite slave front-end driving one port of a byte-enable RAM whose read
// data is registered (valid the cycle after ramEn, held while ramEn is low).
// Each accepted transaction becomes exactly one single-cycle RAM access.
// When writes and reads are both pending, the grant alternates between them.
//
// Ports
//   clk, rstN                         clock, async active-low reset
//   awAddr/awValid/awReady            write address channel
//   wData/wStrb/wValid/wReady         write data channel (accepted together with AW)
//   bResp/bValid/bReady               write response channel
//   arAddr/arValid/arReady            read address channel
//   rData/rResp/rValid/rReady         read data channel (rData muxes ramRead)
//   ramAddr/ramWrite/ramStrb/ramEn    RAM port command
//   ramRead                           RAM port registered read data
//
// Optional build macro AXIL_RAM_RANGE_CHECK_EN: word addresses >= DEPTH_WORDS
// suppress the RAM access and answer SLVERR (reads return zero data). Without
// it, addresses alias modulo 2^RAM_ADDR_W and every response is OKAY.
module axil_ram_ctrl #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned RAM_ADDR_W  = ADDR_W - $clog2(DATA_W / 8),
  parameter int unsigned DEPTH_WORDS = 1 << RAM_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rstN,
  input  logic [ADDR_W-1:0]       awAddr,
  input  logic                    awValid,
  output logic                    awReady,
  input  logic [DATA_W-1:0]       wData,
  input  logic [DATA_W/8-1:0]     wStrb,
  input  logic                    wValid,
  output logic                    wReady,
  output logic [1:0]              bResp,
  output logic                    bValid,
  input  logic                    bReady,
  input  logic [ADDR_W-1:0]       arAddr,
  input  logic                    arValid,
  output logic                    arReady,
  output logic [DATA_W-1:0]       rData,
  output logic [1:0]              rResp,
  output logic                    rValid,
  input  logic                    rReady,
  output logic [RAM_ADDR_W-1:0]   ramAddr,
  output logic [DATA_W-1:0]       ramWrite,
  output logic [DATA_W/8-1:0]     ramStrb,
  output logic                    ramEn,
  input  logic [DATA_W-1:0]       ramRead
);

  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned BYTE_SH = $clog2(STRB_W);
  localparam logic [1:0]  OKAY    = 2'b00;
  localparam logic [1:0]  SLVERR  = 2'b10;

  if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_data_w
    $error("axil_ram_ctrl: DATA_W must be a multiple of 8 and at least 8");
  end
  if (64'(DEPTH_WORDS) > (64'd1 << RAM_ADDR_W)) begin : g_bad_depth
    $error("axil_ram_ctrl: DEPTH_WORDS exceeds the RAM address space");
  end

  typedef enum logic [2:0] {IDLE, WR_ACC, WR_RESP, RD_ACC, RD_RESP} state_t;

  state_t                  state, stateD;
  logic                    awReadyD, wReadyD, arReadyD, bValidD, rValidD;
  logic [1:0]              bRespD, rRespD;
  logic [RAM_ADDR_W-1:0]   ramAddrD;
  logic [DATA_W-1:0]       ramWriteD;
  logic [STRB_W-1:0]       ramStrbD, strbQ, strbQD;
  logic                    ramEnD;
  logic                    lastRead, lastReadD;
  logic                    oorQ, oorQD;
  logic                    wrOor, rdOor;

`ifdef AXIL_RAM_RANGE_CHECK_EN
  assign wrOor = 32'(awAddr >> BYTE_SH) >= DEPTH_WORDS;
  assign rdOor = 32'(arAddr >> BYTE_SH) >= DEPTH_WORDS;
  assign rData = oorQ ? '0 : ramRead;
`else
  assign wrOor = 1'b0;
  assign rdOor = 1'b0;
  assign rData = ramRead;
`endif

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state    <= IDLE;
      awReady  <= 1'b0;
      wReady   <= 1'b0;
      arReady  <= 1'b0;
      bValid   <= 1'b0;
      bResp    <= '0;
      rValid   <= 1'b0;
      rResp    <= '0;
      ramAddr  <= '0;
      ramWrite <= '0;
      ramStrb  <= '0;
      ramEn    <= 1'b0;
      strbQ    <= '0;
      oorQ     <= 1'b0;
      lastRead <= 1'b1;
    end else begin
      state    <= stateD;
      awReady  <= awReadyD;
      wReady   <= wReadyD;
      arReady  <= arReadyD;
      bValid   <= bValidD;
      bResp    <= bRespD;
      rValid   <= rValidD;
      rResp    <= rRespD;
      ramAddr  <= ramAddrD;
      ramWrite <= ramWriteD;
      ramStrb  <= ramStrbD;
      ramEn    <= ramEnD;
      strbQ    <= strbQD;
      oorQ     <= oorQD;
      lastRead <= lastReadD;
    end
  end

  // All outputs are registered, so a grant is decided one cycle early: IDLE
  // raises the ready(s) and latches the request; the following IDLE cycle,
  // with ready still high, is the handshake and issues the RAM access.
  always_comb begin
    stateD    = state;
    awReadyD  = awReady;
    wReadyD   = wReady;
    arReadyD  = arReady;
    bValidD   = bValid;
    bRespD    = bResp;
    rValidD   = rValid;
    rRespD    = rResp;
    ramAddrD  = ramAddr;
    ramWriteD = ramWrite;
    ramStrbD  = '0;
    ramEnD    = 1'b0;
    strbQD    = strbQ;
    oorQD     = oorQ;
    lastReadD = lastRead;
    unique case (state)
      IDLE: begin
        if (awReady) begin
          awReadyD = 1'b0;
          wReadyD  = 1'b0;
          ramEnD   = ~oorQ;
          ramStrbD = oorQ ? '0 : strbQ;
          stateD   = WR_ACC;
        end else if (arReady) begin
          arReadyD = 1'b0;
          ramEnD   = ~oorQ;
          stateD   = RD_ACC;
        end else if (awValid && wValid && (!arValid || lastRead)) begin
          awReadyD  = 1'b1;
          wReadyD   = 1'b1;
          ramAddrD  = RAM_ADDR_W'(awAddr >> BYTE_SH);
          ramWriteD = wData;
          strbQD    = wStrb;
          oorQD     = wrOor;
        end else if (arValid) begin
          arReadyD = 1'b1;
          ramAddrD = RAM_ADDR_W'(arAddr >> BYTE_SH);
          oorQD    = rdOor;
        end
      end
      WR_ACC: begin
        bValidD   = 1'b1;
        bRespD    = oorQ ? SLVERR : OKAY;
        lastReadD = 1'b0;
        stateD    = WR_RESP;
      end
      WR_RESP: begin
        if (bReady) begin
          bValidD = 1'b0;
          bRespD  = OKAY;
          stateD  = IDLE;
        end
      end
      RD_ACC: begin
        rValidD   = 1'b1;
        rRespD    = oorQ ? SLVERR : OKAY;
        lastReadD = 1'b1;
        stateD    = RD_RESP;
      end
      RD_RESP: begin
        if (rReady) begin
          rValidD = 1'b0;
          rRespD  = OKAY;
          stateD  = IDLE;
        end
      end
      default: stateD = IDLE;
    endcase
  end

endmodule
